// File: rtl/parity_rx_if.sv
// Receive-side bus of the serial parity checker: serial beat inputs plus
// the assembled word, status flags and link-health counter.
interface parity_rx_if #(
  parameter int BW_DATA = 8,
  parameter int BW_CNT  = 8
);
  logic               i_bit;
  logic               i_bit_vld;
  logic               i_sop;
  logic               i_clr_cnt;
  logic [BW_DATA-1:0] o_data;
  logic               o_vld;
  logic               o_err;
  logic [BW_CNT-1:0]  o_err_cnt;
  logic               o_busy;

  // Upstream side: drives serial beats, observes the checker results
  modport master (
    output i_bit, i_bit_vld, i_sop, i_clr_cnt,
    input  o_data, o_vld, o_err, o_err_cnt, o_busy
  );

  // Checker side
  modport slave (
    input  i_bit, i_bit_vld, i_sop, i_clr_cnt,
    output o_data, o_vld, o_err, o_err_cnt, o_busy
  );
endinterface

// File: rtl/parity_rx.sv
// Serial parity receiver: deserializes BW_DATA data bits (LSB first) plus a
// parity bit, flags parity mismatches and keeps a saturating error count.
module parity_rx #(
  parameter int BW_DATA    = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int BW_CNT     = 8
) (
  input logic        i_clk,
  input logic        i_rst,
  parity_rx_if.slave bus
);

  localparam int                CW       = $clog2(BW_DATA) + 1;
  localparam logic [CW-1:0]     LAST_IDX = CW'(BW_DATA - 1);
  localparam logic [CW-1:0]     FIRST_CNT = CW'(1);
  localparam logic [BW_CNT-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW_DATA-1:0] shreg_q, shreg_d;
  logic [BW_DATA-1:0] data_q, data_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic [BW_CNT-1:0]  err_cnt_q, err_cnt_d;
  logic               frame_done;
  logic               frame_err;

  // Mismatch between received parity and the parity the word should carry
  function automatic logic parity_check(input logic [BW_DATA-1:0] word,
                                        input logic               p);
    return (^word) ^ p ^ PARITY_ODD;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [BW_CNT-1:0] sat_inc(input logic [BW_CNT-1:0] v);
    return (v == CNT_MAX) ? v : v + BW_CNT'(1);
  endfunction

  // Writes one bit into the word at the position held by the bit counter
  function automatic logic [BW_DATA-1:0] insert_bit(input logic [BW_DATA-1:0] w,
                                                    input logic [CW-1:0]      idx,
                                                    input logic               b);
    logic [BW_DATA-1:0] r;
    r = w;
    for (int i = 0; i < BW_DATA; i++) begin
      if (idx == CW'(i)) r[i] = b;
    end
    return r;
  endfunction

  // FSM state, bit counter and shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: a valid SOP beat always (re)starts a frame, so a partial
  // frame is silently dropped when a new SOP arrives mid-frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (bus.i_bit_vld) begin
      if (bus.i_sop) begin
        shreg_d = {{(BW_DATA-1){1'b0}}, bus.i_bit};
        cnt_d   = FIRST_CNT;
        state_d = DATA;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = IDLE;
          end
          DATA: begin
            shreg_d = insert_bit(shreg_q, cnt_q, bus.i_bit);
            cnt_d   = cnt_q + FIRST_CNT;
            if (cnt_q == LAST_IDX) state_d = PAR;
          end
          PAR: begin
            cnt_d   = '0;
            state_d = IDLE;
          end
          default: begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Output decode: the parity beat in PAR completes a frame; the clear
  // request overrides any increment landing in the same cycle
  always_comb begin
    frame_done = bus.i_bit_vld && !bus.i_sop && (state_q == PAR);
    frame_err  = parity_check(shreg_q, bus.i_bit);
    data_d     = data_q;
    err_d      = err_q;
    vld_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (frame_done) begin
      vld_d  = 1'b1;
      data_d = shreg_q;
      err_d  = frame_err;
      if (frame_err) err_cnt_d = sat_inc(err_cnt_q);
    end
    if (bus.i_clr_cnt) err_cnt_d = '0;
  end

  // Registered outputs; word and flag hold until the next completed frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      data_q    <= data_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_vld     = vld_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;
  assign bus.o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: three instances share one stimulus stream
// (default, 2-bit counter, odd parity).
module tb_parity_rx;

  logic clk = 1'b0;
  logic rst_s, bit_s, vld_s, sop_s, clr_s;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vld_cnt_a = 0;

  always #5 clk = ~clk;

  parity_rx_if #(.BW_DATA(8), .BW_CNT(8)) ifa ();
  parity_rx_if #(.BW_DATA(8), .BW_CNT(2)) ifb ();
  parity_rx_if #(.BW_DATA(8), .BW_CNT(8)) ifc ();

  assign ifa.i_bit = bit_s;  assign ifa.i_bit_vld = vld_s;
  assign ifa.i_sop = sop_s;  assign ifa.i_clr_cnt = clr_s;
  assign ifb.i_bit = bit_s;  assign ifb.i_bit_vld = vld_s;
  assign ifb.i_sop = sop_s;  assign ifb.i_clr_cnt = clr_s;
  assign ifc.i_bit = bit_s;  assign ifc.i_bit_vld = vld_s;
  assign ifc.i_sop = sop_s;  assign ifc.i_clr_cnt = clr_s;

  parity_rx #(.BW_DATA(8), .PARITY_ODD(1'b0), .BW_CNT(8)) dut_a (
    .i_clk(clk), .i_rst(rst_s), .bus(ifa));
  parity_rx #(.BW_DATA(8), .PARITY_ODD(1'b0), .BW_CNT(2)) dut_b (
    .i_clk(clk), .i_rst(rst_s), .bus(ifb));
  parity_rx #(.BW_DATA(8), .PARITY_ODD(1'b1), .BW_CNT(8)) dut_c (
    .i_clk(clk), .i_rst(rst_s), .bus(ifc));

  // Counts o_vld pulses of instance A (each pulse counted at the edge ending it)
  always @(posedge clk) begin
    if (ifa.o_vld) vld_cnt_a <= vld_cnt_a + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [7:0] exp_data;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one valid beat, then advance to the next falling edge
  task automatic send_beat(input logic b, input logic sop);
    bit_s = b;
    sop_s = sop;
    vld_s = 1'b1;
    @(negedge clk);
  endtask

  task automatic stall(input int n);
    vld_s = 1'b0;
    sop_s = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Full frame; returns at the falling edge where o_vld should be high
  task automatic send_frame(input logic [7:0] d, input logic p, input logic clr_on_par);
    for (int i = 0; i < 8; i++) send_beat(d[i], (i == 0));
    clr_s = clr_on_par;
    send_beat(p, 1'b0);
    clr_s = 1'b0;
  endtask

  vec_t vecs[7];
  int   exp_sat[5];
  int   v0;
  int   busy_bad;
  int   vld_bad;

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b0, exp_data: 8'hA5, exp_err: 1'b0, exp_cnt: 8'd0};
    vecs[1] = '{data: 8'h07, par: 1'b0, exp_data: 8'h07, exp_err: 1'b1, exp_cnt: 8'd1};
    vecs[2] = '{data: 8'h07, par: 1'b1, exp_data: 8'h07, exp_err: 1'b0, exp_cnt: 8'd1};
    vecs[3] = '{data: 8'h80, par: 1'b1, exp_data: 8'h80, exp_err: 1'b0, exp_cnt: 8'd1};
    vecs[4] = '{data: 8'h00, par: 1'b1, exp_data: 8'h00, exp_err: 1'b1, exp_cnt: 8'd2};
    vecs[5] = '{data: 8'hFE, par: 1'b0, exp_data: 8'hFE, exp_err: 1'b1, exp_cnt: 8'd3};
    vecs[6] = '{data: 8'h55, par: 1'b0, exp_data: 8'h55, exp_err: 1'b0, exp_cnt: 8'd3};
    exp_sat = '{1, 2, 3, 3, 3};

    rst_s = 1'b1; bit_s = 1'b0; vld_s = 1'b0; sop_s = 1'b0; clr_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
    chk("reset o_data",    32'(ifa.o_data),    32'h0);
    chk("reset o_vld",     32'(ifa.o_vld),     32'h0);
    chk("reset o_err",     32'(ifa.o_err),     32'h0);
    chk("reset o_err_cnt", 32'(ifa.o_err_cnt), 32'h0);
    chk("reset o_busy",    32'(ifa.o_busy),    32'h0);

    // Table-driven frames on the default instance
    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].data, vecs[k].par, 1'b0);
      chk($sformatf("vec%0d o_vld", k),     32'(ifa.o_vld),     32'h1);
      chk($sformatf("vec%0d o_data", k),    32'(ifa.o_data),    32'(vecs[k].exp_data));
      chk($sformatf("vec%0d o_err", k),     32'(ifa.o_err),     32'(vecs[k].exp_err));
      chk($sformatf("vec%0d o_err_cnt", k), 32'(ifa.o_err_cnt), 32'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d o_busy", k),    32'(ifa.o_busy),    32'h0);
      stall(1);
      chk($sformatf("vec%0d vld drop", k),  32'(ifa.o_vld),     32'h0);
      chk($sformatf("vec%0d data hold", k), 32'(ifa.o_data),    32'(vecs[k].exp_data));
    end

    // Stalled frame 0x3C, then back-to-back 0xFF starting on the o_vld cycle
    v0 = vld_cnt_a;
    busy_bad = 0;
    vld_bad = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(1'((8'h3C >> i) & 8'h01), (i == 0));
      vld_s = 1'b0;
      sop_s = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (ifa.o_busy !== 1'b1) busy_bad++;
        if (ifa.o_vld !== 1'b0) vld_bad++;
      end
    end
    send_beat(1'b0, 1'b0);
    chk("stall busy held",  32'(busy_bad),       32'h0);
    chk("stall no early vld", 32'(vld_bad),      32'h0);
    chk("stall o_vld",      32'(ifa.o_vld),      32'h1);
    chk("stall o_data",     32'(ifa.o_data),     32'h3C);
    chk("stall o_err",      32'(ifa.o_err),      32'h0);
    send_frame(8'hFF, 1'b0, 1'b0);
    chk("b2b o_vld",        32'(ifa.o_vld),      32'h1);
    chk("b2b o_data",       32'(ifa.o_data),     32'hFF);
    chk("b2b o_err",        32'(ifa.o_err),      32'h0);
    stall(2);
    chk("b2b vld pulses",   32'(vld_cnt_a - v0), 32'd2);
    chk("b2b err_cnt kept", 32'(ifa.o_err_cnt),  32'd3);

    // Abort in DATA: 4 bits then a new SOP frame 0x81
    v0 = vld_cnt_a;
    send_beat(1'b1, 1'b1);
    repeat (3) send_beat(1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0);
    chk("abort o_data",     32'(ifa.o_data),     32'h81);
    chk("abort o_err",      32'(ifa.o_err),      32'h0);
    chk("abort err_cnt",    32'(ifa.o_err_cnt),  32'd3);
    stall(2);
    chk("abort vld pulses", 32'(vld_cnt_a - v0), 32'd1);

    // Abort in PAR: 8 data bits, then SOP instead of the parity bit
    v0 = vld_cnt_a;
    for (int i = 0; i < 8; i++) send_beat(1'b1, (i == 0));
    chk("par-abort busy",   32'(ifa.o_busy),     32'h1);
    send_frame(8'h12, 1'b0, 1'b0);
    chk("par-abort o_data", 32'(ifa.o_data),     32'h12);
    stall(2);
    chk("par-abort pulses", 32'(vld_cnt_a - v0), 32'd1);

    // Reset mid-frame after 5 bits, with a valid beat on the reset edge
    v0 = vld_cnt_a;
    send_beat(1'b1, 1'b1);
    repeat (4) send_beat(1'b1, 1'b0);
    chk("pre-rst busy",     32'(ifa.o_busy),     32'h1);
    rst_s = 1'b1;
    bit_s = 1'b1;
    vld_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    vld_s = 1'b0;
    chk("rst o_data",       32'(ifa.o_data),     32'h0);
    chk("rst o_err",        32'(ifa.o_err),      32'h0);
    chk("rst o_err_cnt",    32'(ifa.o_err_cnt),  32'h0);
    chk("rst o_busy",       32'(ifa.o_busy),     32'h0);
    stall(3);
    chk("rst no vld",       32'(vld_cnt_a - v0), 32'd0);

    // Saturation on the 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 1'b0, 1'b0);
      chk($sformatf("sat%0d o_err", k),     32'(ifb.o_err),     32'h1);
      chk($sformatf("sat%0d o_err_cnt", k), 32'(ifb.o_err_cnt), 32'(exp_sat[k]));
      stall(1);
    end
    send_frame(8'h01, 1'b0, 1'b1);
    chk("clr o_err",        32'(ifb.o_err),      32'h1);
    chk("clr beats inc B",  32'(ifb.o_err_cnt),  32'h0);
    chk("clr beats inc A",  32'(ifa.o_err_cnt),  32'h0);
    stall(1);

    // Odd parity instance
    send_frame(8'h00, 1'b1, 1'b0);
    chk("odd good o_vld",   32'(ifc.o_vld),      32'h1);
    chk("odd good o_err",   32'(ifc.o_err),      32'h0);
    stall(1);
    send_frame(8'h00, 1'b0, 1'b0);
    chk("odd bad o_err",    32'(ifc.o_err),      32'h1);
    chk("odd bad err_cnt",  32'(ifc.o_err_cnt),  32'd1);
    stall(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
